// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin search helper for the grant scheduler
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] index;
  } pick_t;

  // Vectors are sized for the largest legal N; only the low n positions are searched.
  function automatic pick_t rr_pick(input logic [15:0] req,
                                    input logic [3:0]  last,
                                    input logic [15:0] mask,
                                    input int          n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k <= n && !r.found) begin
        j = (int'(last) + k) % n;
        if (req[j] && !mask[j]) begin
          r.found = 1'b1;
          r.index = 4'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - binary index to one-hot expansion with an enable gate
module onehot_decoder #(
  parameter int W = 2
) (
  input  logic [W-1:0]      in,
  input  logic              enable,
  output logic [2**W-1:0]   out
);

  localparam int O = 2**W;

  assign out = enable ? ({{(O-1){1'b0}}, 1'b1} << in) : '0;

endmodule

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin grant scheduler with per-tenure hold cap
module rr_grant_scheduler
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  state_t          state, state_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [IW-1:0]   id_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [15:0]     req_ext;
  logic [15:0]     own_mask;
  logic [3:0]      last_ext;
  pick_t           pick_any;
  pick_t           pick_oth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt_id <= '0;
      last   <= IW'(N - 1);
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      gnt_id <= id_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    req_ext            = '0;
    req_ext[N-1:0]     = req;
    last_ext           = '0;
    last_ext[IW-1:0]   = last;
    own_mask           = '0;
    own_mask[gnt_id]   = 1'b1;
    pick_any           = rr_pick(req_ext, last_ext, 16'h0000, N);
    pick_oth           = rr_pick(req_ext, last_ext, own_mask, N);

    state_nxt = state;
    id_nxt    = gnt_id;
    last_nxt  = last;
    cnt_nxt   = cnt;

    case (state)
      IDLE: begin
        if (pick_any.found) begin
          state_nxt = GRANT;
          id_nxt    = IW'(pick_any.index);
          last_nxt  = IW'(pick_any.index);
          cnt_nxt   = CW'(1);
        end
      end
      GRANT: begin
        // Handover happens on release, or on expiry of the hold cap under contention.
        if ((!req[gnt_id] || cnt == HOLD_MAX) && pick_oth.found) begin
          id_nxt   = IW'(pick_oth.index);
          last_nxt = IW'(pick_oth.index);
          cnt_nxt  = CW'(1);
        end else if (!req[gnt_id]) begin
          state_nxt = IDLE;
          id_nxt    = '0;
          cnt_nxt   = '0;
        end else if (cnt != HOLD_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        id_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign gnt_valid = (state == GRANT);

  onehot_decoder #(.W(IW)) u_dec (
    .in     (gnt_id),
    .enable (gnt_valid),
    .out    (gnt)
  );

endmodule
